// File: rtl/gray_decoder_if.sv
// gray_decoder_if: sample/fault-ack inputs and decoded status outputs of the Gray-code decoder
//   master: source side, drives gray_in/sample_en/error_ack and observes the results
//   slave : decoder side, receives the inputs and drives bin_out/position/step_valid/dir/locked/error
interface gray_decoder_if #(
  parameter int WIDTH     = 2,
  parameter int POS_WIDTH = 8
);
  logic [WIDTH-1:0]     gray_in;
  logic                 sample_en;
  logic                 error_ack;
  logic [WIDTH-1:0]     bin_out;
  logic [POS_WIDTH-1:0] position;
  logic                 step_valid;
  logic                 dir;
  logic                 locked;
  logic                 error;
  modport master (
    output gray_in, sample_en, error_ack,
    input  bin_out, position, step_valid, dir, locked, error
  );
  modport slave (
    input  gray_in, sample_en, error_ack,
    output bin_out, position, step_valid, dir, locked, error
  );
endinterface

// File: rtl/gray_decoder.sv
// gray_decoder: samples a Gray-coded count, converts it to binary, classifies each step and tracks position
//   clock   : rising-edge clock
//   clear_n : asynchronous active-low reset
//   bus_if  : gray_decoder_if.slave (gray_in, sample_en, error_ack in; bin_out, position, step_valid, dir, locked, error out)
module gray_decoder #(
  parameter int WIDTH     = 2,
  parameter int POS_WIDTH = 8
) (
  input logic          clock,
  input logic          clear_n,
  gray_decoder_if.slave bus_if
);
  typedef enum logic [1:0] {UNLOCKED, LOCKED, FAULT} state_t;
  state_t               state_q, state_d;
  logic [WIDTH-1:0]     bin_c, diff_c;
  logic [WIDTH-1:0]     prev_bin_q, prev_bin_d;
  logic [WIDTH-1:0]     bin_out_q, bin_out_d;
  logic [POS_WIDTH-1:0] pos_q, pos_d;
  logic                 step_valid_q, step_valid_d;
  logic                 dir_q, dir_d;
  logic                 locked_q, locked_d;
  logic                 error_q, error_d;
  logic                 up_c, dn_c, hold_c, bad_c;
  // each binary bit is the XOR of all Gray bits at and above it
  for (genvar i = 0; i < WIDTH; i++) begin : g_conv
    assign bin_c[i] = ^bus_if.gray_in[WIDTH-1:i];
  end
  assign diff_c = bin_c - prev_bin_q;
  assign hold_c = diff_c == '0;
  assign up_c   = diff_c == WIDTH'(1);
  assign dn_c   = diff_c == '1;
  assign bad_c  = !(hold_c || up_c || dn_c);
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      state_q      <= UNLOCKED;
      prev_bin_q   <= '0;
      bin_out_q    <= '0;
      pos_q        <= '0;
      step_valid_q <= 1'b0;
      dir_q        <= 1'b0;
      locked_q     <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      prev_bin_q   <= prev_bin_d;
      bin_out_q    <= bin_out_d;
      pos_q        <= pos_d;
      step_valid_q <= step_valid_d;
      dir_q        <= dir_d;
      locked_q     <= locked_d;
      error_q      <= error_d;
    end
  end
  // error_ack takes priority in FAULT; any sample in that cycle is dropped
  always_comb begin
    state_d = state_q;
    case (state_q)
      UNLOCKED: state_d = bus_if.sample_en ? LOCKED : UNLOCKED;
      LOCKED:   state_d = (bus_if.sample_en && bad_c) ? FAULT : LOCKED;
      FAULT:    state_d = bus_if.error_ack ? UNLOCKED : FAULT;
      default:  state_d = UNLOCKED;
    endcase
  end
  always_comb begin
    prev_bin_d   = prev_bin_q;
    bin_out_d    = bin_out_q;
    pos_d        = pos_q;
    step_valid_d = 1'b0;
    dir_d        = dir_q;
    error_d      = error_q;
    if (state_q == UNLOCKED && bus_if.sample_en) begin
      prev_bin_d = bin_c;
      bin_out_d  = bin_c;
      pos_d      = '0;
    end
    if (state_q == LOCKED && bus_if.sample_en) begin
      // an illegal jump freezes position and the reference sample
      prev_bin_d   = bad_c ? prev_bin_q : bin_c;
      bin_out_d    = bad_c ? bin_out_q : bin_c;
      pos_d        = up_c ? pos_q + POS_WIDTH'(1) : dn_c ? pos_q - POS_WIDTH'(1) : pos_q;
      dir_d        = up_c ? 1'b1 : dn_c ? 1'b0 : dir_q;
      step_valid_d = up_c || dn_c;
      error_d      = bad_c;
    end
    if (state_q == FAULT && bus_if.error_ack) error_d = 1'b0;
    locked_d = state_d == LOCKED;
  end
  assign bus_if.bin_out    = bin_out_q;
  assign bus_if.position   = pos_q;
  assign bus_if.step_valid = step_valid_q;
  assign bus_if.dir        = dir_q;
  assign bus_if.locked     = locked_q;
  assign bus_if.error      = error_q;
endmodule

// File: tb/tb_gray_decoder.sv
// tb_gray_decoder: scoreboard bench for gray_decoder against a behavioural step/position model
module tb_gray_decoder;
  localparam int W = 2;
  localparam int P = 8;
  localparam int M = 1 << W;
  typedef struct {
    int bin;
    int pos;
    int sv;
    int dir;
    int lk;
    int er;
  } exp_t;
  logic clock = 1'b0;
  logic clear_n = 1'b0;
  int total = 0;
  int bad = 0;
  exp_t q[$];
  // model: 0 unlocked, 1 locked, 2 fault
  int m_st = 0, m_prev = 0, m_pos = 0, m_dir = 0, m_err = 0;
  gray_decoder_if #(.WIDTH(W), .POS_WIDTH(P)) dif ();
  gray_decoder #(.WIDTH(W), .POS_WIDTH(P)) dut (.clock(clock), .clear_n(clear_n), .bus_if(dif.slave));
  always #5 clock = ~clock;
  function automatic int b2g(input int n);
    return n ^ (n >> 1);
  endfunction
  function automatic int g2b(input int g);
    for (int n = 0; n < M; n++) if (b2g(n) == g) return n;
    return 0;
  endfunction
  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  task automatic cyc(input int g, input bit se, input bit ack);
    int b, d, sv;
    exp_t e;
    @(negedge clock);
    dif.gray_in = W'(g);
    dif.sample_en = se;
    dif.error_ack = ack;
    b = g2b(g);
    sv = 0;
    if (m_st == 2) begin
      if (ack) begin m_st = 0; m_err = 0; end
    end else if (m_st == 0) begin
      if (se) begin m_st = 1; m_prev = b; m_pos = 0; end
    end else if (se) begin
      d = (b - m_prev + M) % M;
      if (d == 1) begin m_pos = (m_pos + 1) % 256; m_dir = 1; sv = 1; m_prev = b; end
      else if (d == M - 1) begin m_pos = (m_pos + 255) % 256; m_dir = 0; sv = 1; m_prev = b; end
      else if (d != 0) begin m_st = 2; m_err = 1; end
    end
    e.bin = m_prev; e.pos = m_pos; e.sv = sv; e.dir = m_dir; e.lk = (m_st == 1); e.er = m_err;
    q.push_back(e);
    @(posedge clock);
  endtask
  task automatic chk_reset_vals();
    chk("rst_bin", int'(dif.bin_out), 0);
    chk("rst_pos", int'(dif.position), 0);
    chk("rst_sv", int'(dif.step_valid), 0);
    chk("rst_dir", int'(dif.dir), 0);
    chk("rst_locked", int'(dif.locked), 0);
    chk("rst_error", int'(dif.error), 0);
  endtask
  task automatic unlock_via_fault();
    cyc(b2g((m_prev + 2) % M), 1, 0);
    cyc(0, 0, 1);
  endtask
  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("bin_out", int'(dif.bin_out), e.bin);
        chk("position", int'(dif.position), e.pos);
        chk("step_valid", int'(dif.step_valid), e.sv);
        chk("dir", int'(dif.dir), e.dir);
        chk("locked", int'(dif.locked), e.lk);
        chk("error", int'(dif.error), e.er);
      end
    end
  end
  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
  initial begin
    int b;
    dif.gray_in = '0;
    dif.sample_en = 1'b0;
    dif.error_ack = 1'b0;
    #12;
    chk_reset_vals();
    @(negedge clock);
    clear_n = 1'b1;
    // lock and count up
    cyc('b01, 1, 0);
    cyc('b11, 1, 0);
    cyc('b10, 1, 0);
    cyc('b00, 1, 0);
    cyc('b01, 1, 0);
    // count down and wrap below zero
    unlock_via_fault();
    cyc('b00, 1, 0);
    cyc('b10, 1, 0);
    cyc('b11, 1, 0);
    cyc('b01, 1, 0);
    cyc('b00, 1, 0);
    cyc('b10, 1, 0);
    // hold and ignored gray changes while sample_en is low
    unlock_via_fault();
    cyc('b11, 1, 0);
    cyc('b11, 1, 0);
    cyc('b11, 1, 0);
    cyc('b00, 0, 0);
    cyc('b01, 0, 0);
    cyc('b10, 0, 0);
    // illegal jump, ignored samples, ack wins over sample, relock
    unlock_via_fault();
    cyc('b00, 1, 0);
    cyc('b11, 1, 0);
    cyc('b01, 1, 0);
    cyc('b01, 0, 0);
    cyc('b01, 1, 1);
    cyc('b01, 1, 0);
    // 128 up steps wrap the accumulator to 0x80
    unlock_via_fault();
    cyc(0, 1, 0);
    b = 0;
    for (int i = 0; i < 128; i++) begin
      b = (b + 1) % M;
      cyc(b2g(b), 1, 0);
    end
    // async reset mid-count at position 3
    unlock_via_fault();
    cyc(0, 1, 0);
    for (int i = 1; i <= 3; i++) cyc(b2g(i), 1, 0);
    #3;
    clear_n = 1'b0;
    #1;
    chk_reset_vals();
    m_st = 0; m_prev = 0; m_pos = 0; m_dir = 0; m_err = 0;
    @(negedge clock);
    clear_n = 1'b1;
    cyc('b10, 1, 0);
    cyc('b10, 1, 0);
    // random stimulus biased towards legal steps
    for (int i = 0; i < 400; i++) begin
      int r, g;
      r = int'($urandom_range(0, 9));
      if (r < 4) g = b2g((m_prev + 1) % M);
      else if (r < 7) g = b2g((m_prev + M - 1) % M);
      else if (r < 8) g = b2g(m_prev);
      else g = int'($urandom_range(0, M - 1));
      cyc(g, $urandom_range(0, 3) != 0, $urandom_range(0, 5) == 0);
    end
    @(posedge clock);
    #2;
    chk("drain", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
